// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_if
// Description : Bus bundle for the multi-port register file.
//               The master side (issue/writeback stages) drives read
//               addresses, the two write ports and the issue port. The
//               slave side (the register file) returns read data, per-port
//               busy flags, ready and wr_conflict.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREG);

    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  wa_en;
    logic [AW-1:0]         wa_addr;
    logic [XLEN-1:0]       wa_data;
    logic                  wb_en;
    logic [AW-1:0]         wb_addr;
    logic [XLEN-1:0]       wb_data;
    logic                  iss_en;
    logic [AW-1:0]         iss_addr;
    logic                  ready;
    logic                  wr_conflict;

    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               iss_en, iss_addr,
        input  rd_data, rd_busy, ready, wr_conflict
    );

    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               iss_en, iss_addr,
        output rd_data, rd_busy, ready, wr_conflict
    );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-port integer register file with two write ports
//               (B has priority over A), zero-cycle write-to-read bypass,
//               per-register busy scoreboard and a post-reset sequential
//               clear engine (one entry per cycle, no flash clear).
// Ports       : clk  - clock, all state on rising edge
//               rst  - synchronous active-high reset
//               bus  - regfile_mp_if.slave: read ports, write ports A/B,
//                      issue port, ready and wr_conflict
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NREAD = 2
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus
);
    localparam int AW = $clog2(NREG);

    localparam logic [0:0]    c_st_clear = 1'b0;
    localparam logic [0:0]    c_st_run   = 1'b1;
    localparam logic [AW-1:0] c_last_idx = AW'(NREG - 1);

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [XLEN-1:0] r_mem [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            r_wr_conflict;
    logic            w_ready;
    logic            w_wa_hit;
    logic            w_wb_hit;
    logic            w_iss_hit;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_clear;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_st_clear && r_cnt == c_last_idx) begin
            w_state_nxt = c_st_run;
        end
    end

    // ---------------- FSM: outputs ----------------
    // ready comes straight off the state flop, so it is registered.
    always_comb begin
        w_ready = (r_state == c_st_run);
    end

    // Accepted operations: only in RUN and never to register 0.
    assign w_wa_hit  = w_ready & bus.wa_en  & (bus.wa_addr  != '0);
    assign w_wb_hit  = w_ready & bus.wb_en  & (bus.wb_addr  != '0);
    assign w_iss_hit = w_ready & bus.iss_en & (bus.iss_addr != '0);

    // Clear counter: restarts on every reset, walks the array in CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == c_st_clear) begin
            r_cnt <= r_cnt + AW'(1);
        end
    end

    // Storage is deliberately not reset; the clear engine zeroes it so the
    // array can map onto RAM. Port B is written last, so on an address
    // collision its value is the one that sticks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == c_st_clear) begin
                r_mem[r_cnt] <= '0;
            end else begin
                if (w_wa_hit) r_mem[bus.wa_addr] <= bus.wa_data;
                if (w_wb_hit) r_mem[bus.wb_addr] <= bus.wb_data;
            end
        end
    end

    // Scoreboard: writes clear, then issue sets, so a same-cycle issue wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wa_hit)  w_busy_nxt[bus.wa_addr]  = 1'b0;
        if (w_wb_hit)  w_busy_nxt[bus.wb_addr]  = 1'b0;
        if (w_iss_hit) w_busy_nxt[bus.iss_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= '0;
            r_wr_conflict <= 1'b0;
        end else begin
            r_busy        <= w_busy_nxt;
            r_wr_conflict <= w_wa_hit & w_wb_hit & (bus.wa_addr == bus.wb_addr);
        end
    end

    assign bus.ready       = w_ready;
    assign bus.wr_conflict = r_wr_conflict;

    // ---------------- read ports with bypass ----------------
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic            w_active;
        logic            w_wa_match;
        logic            w_wb_match;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_addr     = bus.rd_addr[k*AW +: AW];
        assign w_active   = w_ready & (w_addr != '0);
        // The hit terms already imply RUN and a nonzero address.
        assign w_wa_match = w_wa_hit & (bus.wa_addr == w_addr);
        assign w_wb_match = w_wb_hit & (bus.wb_addr == w_addr);

        always_comb begin
            w_data = '0;
            if (w_active) begin
                if (w_wb_match)      w_data = bus.wb_data;
                else if (w_wa_match) w_data = bus.wa_data;
                else                 w_data = r_mem[w_addr];
            end
        end

        // A write landing this cycle resolves the hazard for the reader.
        assign w_busy = w_active & r_busy[w_addr] & ~(w_wa_match | w_wb_match);

        assign bus.rd_data[k*XLEN +: XLEN] = w_data;
        assign bus.rd_busy[k]              = w_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Scoreboard bench for regfile_mp. The stimulus process drives
//               directed vectors and queues hand-computed expectations tagged
//               with their cycle; a monitor on the falling edge pops and
//               compares them against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NREAD = 2;

    localparam int K_READY = 0;
    localparam int K_DATA  = 1;
    localparam int K_BUSY  = 2;
    localparam int K_CONF  = 3;

    typedef struct {
        string       name;
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            case (e.kind)
                K_READY: act = {31'b0, bus.ready};
                K_DATA:  act = bus.rd_data[e.port*XLEN +: XLEN];
                K_BUSY:  act = {31'b0, bus.rd_busy[e.port]};
                default: act = {31'b0, bus.wr_conflict};
            endcase
            n_tests++;
            if (e.cyc != cyc || act !== e.exp) begin
                n_fail++;
                $display("FAIL %s (cycle %0d, port %0d): got 0x%08h, expected 0x%08h",
                         e.name, e.cyc, e.port, act, e.exp);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input int kind, input int port,
                        input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.cyc  = cyc;
        e.kind = kind;
        e.port = port;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic set_rd(input int a0, input int a1);
        bus.rd_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic idle();
        bus.wa_en  = 1'b0;
        bus.wb_en  = 1'b0;
        bus.iss_en = 1'b0;
    endtask

    task automatic wr_a(input int a, input logic [31:0] d);
        bus.wa_en = 1'b1; bus.wa_addr = 5'(a); bus.wa_data = d;
    endtask

    task automatic wr_b(input int a, input logic [31:0] d);
        bus.wb_en = 1'b1; bus.wb_addr = 5'(a); bus.wb_data = d;
    endtask

    task automatic issue(input int a);
        bus.iss_en = 1'b1; bus.iss_addr = 5'(a);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        idle();
        bus.wa_addr = '0; bus.wa_data = '0;
        bus.wb_addr = '0; bus.wb_data = '0;
        bus.iss_addr = '0;
        set_rd(5, 5);
        wr_a(5, 32'h0000_5A5A);

        // Reset for two edges, write port A hammering address 5 throughout.
        step();
        push("rst_ready", K_READY, 0, 0);
        push("rst_conf",  K_CONF,  0, 0);
        push("rst_data",  K_DATA,  0, 0);
        push("rst_busy",  K_BUSY,  0, 0);
        step();
        push("rst_ready2", K_READY, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < NREG; i++) begin
            push("clear_ready", K_READY, 0, 0);
            push("clear_data",  K_DATA,  0, 0);
            step();
        end
        push("ready_up",     K_READY, 0, 1);
        push("first_wr_byp", K_DATA,  0, 32'h0000_5A5A);
        step();
        idle();
        push("first_wr_mem", K_DATA, 1, 32'h0000_5A5A);

        // Write priority and bypass ordering.
        step();
        wr_a(7, 32'h1111); wr_b(7, 32'h2222); set_rd(7, 7);
        push("prio_byp",  K_DATA, 0, 32'h2222);
        push("prio_conf0", K_CONF, 0, 0);
        step();
        idle();
        push("prio_mem0", K_DATA, 0, 32'h2222);
        push("prio_mem1", K_DATA, 1, 32'h2222);
        push("prio_conf", K_CONF, 0, 1);
        step();
        push("prio_conf_end", K_CONF, 0, 0);

        // Back-to-back conflicts hold wr_conflict for two cycles.
        wr_a(8, 32'h1); wr_b(8, 32'h2); set_rd(8, 7);
        push("b2b_byp", K_DATA, 0, 32'h2);
        step();
        push("b2b_conf1", K_CONF, 0, 1);
        step();
        idle();
        push("b2b_conf2", K_CONF, 0, 1);
        step();
        push("b2b_conf_end", K_CONF, 0, 0);
        push("b2b_mem",      K_DATA, 0, 32'h2);

        // Register 0 ignores writes and issues.
        step();
        wr_a(0, 32'hDEAD); issue(0); set_rd(0, 0);
        push("x0_data", K_DATA, 0, 0);
        push("x0_busy", K_BUSY, 0, 0);
        push("x0_data1", K_DATA, 1, 0);
        step();
        idle();
        push("x0_data_after", K_DATA, 0, 0);
        push("x0_busy_after", K_BUSY, 0, 0);

        // Scoreboard set and clear.
        step();
        issue(9); set_rd(9, 9);
        push("sb_same_cyc", K_BUSY, 0, 0);
        step();
        idle();
        push("sb_busy0", K_BUSY, 0, 1);
        push("sb_busy1", K_BUSY, 1, 1);
        push("sb_data",  K_DATA, 0, 0);
        step();
        wr_a(9, 32'h55);
        push("sb_wr_busy", K_BUSY, 0, 0);
        push("sb_wr_data", K_DATA, 0, 32'h55);
        step();
        idle();
        push("sb_after_busy", K_BUSY, 0, 0);
        push("sb_after_data", K_DATA, 0, 32'h55);

        // Issue and write to the same register in one cycle: issue wins.
        step();
        issue(12); wr_b(12, 32'hAB); set_rd(12, 0);
        push("race_byp",  K_DATA, 0, 32'hAB);
        push("race_busy0", K_BUSY, 0, 0);
        step();
        idle();
        push("race_data", K_DATA, 0, 32'hAB);
        push("race_busy", K_BUSY, 0, 1);

        // Garbage before a reset that is re-asserted mid-clear.
        step();
        wr_a(3, 32'h33); wr_b(4, 32'h44); issue(20);
        step();
        idle();
        set_rd(3, 4);
        push("pre_r3", K_DATA, 0, 32'h33);
        push("pre_r4", K_DATA, 1, 32'h44);
        step();
        set_rd(20, 12);
        push("pre_busy20", K_BUSY, 0, 1);
        push("pre_r12",    K_DATA, 1, 32'hAB);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push("mid_ready", K_READY, 0, 0);
            step();
        end
        rst = 1'b1;
        push("mid_ready_rst", K_READY, 0, 0);
        step();
        rst = 1'b0;
        wr_a(12, 32'hFFFF_FFFF);
        for (int i = 0; i < NREG; i++) begin
            push("reclear_ready", K_READY, 0, 0);
            push("reclear_data",  K_DATA,  1, 0);
            step();
        end
        idle();
        push("reclear_ready_up", K_READY, 0, 1);
        for (int r = 0; r < NREG; r += 2) begin
            set_rd(r, r + 1);
            push("all_zero_d0", K_DATA, 0, 0);
            push("all_zero_d1", K_DATA, 1, 0);
            push("all_zero_b0", K_BUSY, 0, 0);
            push("all_zero_b1", K_BUSY, 1, 0);
            step();
        end

        step();
        step();
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish within the time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the pipelined core. It replaces the single-write, two-read file with configurable width, depth and read-port count. It adds a second write port (load/CSR writeback beside ALU writeback), same-cycle write-to-read bypass with defined priority, and a per-register busy scoreboard for hazard detection. After reset, a sequential clear engine zeroes the storage one entry per cycle, so the array maps to distributed RAM without a flash clear.

## Interface
- XLEN, 32, data width
- NREG, 32, number of architectural registers (power of two, ≥4); AW = $clog2(NREG)
- NREAD, 2, number of read ports (1–4)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NREAD*AW  read addresses, port k at [k*AW +: AW]
- rd_data  out  NREAD*XLEN  read data, port k at [k*XLEN +: XLEN]
- rd_busy  out  NREAD  addressed register has an outstanding producer
- wa_en / wa_addr / wa_data  in  1 / AW / XLEN  write port A (ALU writeback)
- wb_en / wb_addr / wb_data  in  1 / AW / XLEN  write port B (load/CSR writeback)
- iss_en / iss_addr  in  1 / AW  issue: mark iss_addr busy
- ready  out  1  clear complete; writes and issues accepted
- wr_conflict  out  1  registered pulse: both ports wrote the same register last cycle

## Operation
- States: CLEAR, RUN.
- CLEAR behaviour:
  - A cycle with rst high forces CLEAR, sets cnt=0 and zeroes all busy bits at once.
  - Each cycle in CLEAR with rst low writes 0 to mem[cnt] and increments cnt.
  - After the write of cnt=NREG-1, the next state is RUN.
  - rst asserted mid-clear restarts at cnt=0.
  - In CLEAR: ready=0, all rd_data=0, all rd_busy=0, wa/wb/iss ignored.
- Register 0 is hardwired zero:
  - Writes and issues to address 0 are ignored.
  - Reads of address 0 return 0 with rd_busy=0.
- Write priority: if wa_en and wb_en target the same nonzero address, port B wins. wr_conflict=1 on the next cycle.
- Bypass: for each read port k with nonzero rd_addr[k], the data source is chosen in this order:
  - wb_data, if wb_en and wb_addr matches;
  - otherwise wa_data, if wa_en and wa_addr matches;
  - otherwise mem[rd_addr[k]].
- Scoreboard:
  - Next cycle, busy[r] is set on iss_en for r.
  - Next cycle, busy[r] is cleared on any accepted write to r.
  - If an issue and a write to the same r occur in the same cycle, the issue wins and busy stays 1.
  - rd_busy[k] = busy[rd_addr[k]] AND NOT (an enabled write to rd_addr[k] this cycle). A same-cycle iss_en is not reflected until the next cycle.
- Issuing to an already-busy register is legal; busy stays 1, and the first write clears it. Counting multiple producers is the issue stage's responsibility.

## Timing
- Reads are fully combinational from address and write inputs. Zero-cycle bypass latency.
- Write latency: data is in the array at the rising edge where en is high and is visible via the array from the next cycle.
- Reset values: ready=0, wr_conflict=0, rd_data=0, rd_busy=0, all busy bits 0.
- The array is not reset directly, only through CLEAR.
- ready rises exactly NREG cycles after the first cycle with rst low, and is registered.
- The first accepted write or issue is in the cycle where ready=1.
- wr_conflict is high for exactly one cycle per conflicting cycle; back-to-back conflicts keep it high.

## Test plan
- Reset/clear:
  - Stimulus: rst for 2 cycles, release, with wa_en=1 to address 5 every cycle.
  - Required: ready=0 for 32 cycles then 1; rd_data=0 throughout CLEAR; the first write lands on cycle 33; address 5 reads it afterwards.
- Bypass priority:
  - Stimulus: wa 7←0x1111 and wb 7←0x2222 in one cycle, rd_addr0=7.
  - Required: rd_data0=0x2222 that cycle and after; wr_conflict=1 on the next cycle only.
- x0:
  - Stimulus: wa 0←0xDEAD and iss_en addr 0.
  - Required: reads of 0 return 0 with rd_busy=0, same cycle and later.
- Scoreboard:
  - Stimulus: issue 9; next cycle rd_busy for 9 is 1; wa 9←0x55.
  - Required: rd_busy=0 in the write cycle, rd_data=0x55; busy stays clear afterwards.
- Issue/write race:
  - Stimulus: iss_en 12 and wb 12←0xAB in the same cycle.
  - Required: the next cycle reads 0xAB with rd_busy=1.
- Mid-clear reset:
  - Stimulus: assert rst at cnt=10 after writing garbage pre-reset.
  - Required: ready stays 0 until 32 cycles after the second release; every register reads 0.
